// File: rtl/logip_cmd_ctrl_pkg.sv
// Shared opcodes, FSM state encoding, trigger-field selects and the ID byte
// helper for the LogIP command controller.
package logip_pkg;

    // Host opcodes
    localparam logic [7:0] OP_RESET    = 8'h00;
    localparam logic [7:0] OP_ARM      = 8'h01;
    localparam logic [7:0] OP_ID       = 8'h02;
    localparam logic [7:0] OP_XON      = 8'h11;
    localparam logic [7:0] OP_XOFF     = 8'h13;
    localparam logic [7:0] OP_DIV      = 8'h80;
    localparam logic [7:0] OP_CNT      = 8'h81;
    localparam logic [7:0] OP_FLAGS    = 8'h82;
    localparam logic [7:0] OP_TRG_BASE = 8'hC0;

    // Trigger field select, taken from opcode bits [1:0]
    localparam logic [1:0] TRG_MASK = 2'd0;
    localparam logic [1:0] TRG_VAL  = 2'd1;
    localparam logic [1:0] TRG_CFG  = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_HOLD = 2'd2,
        ST_WAIT = 2'd3
    } ctrl_state_t;

    // Byte idx of the ID word, most significant byte first
    function automatic logic [7:0] id_byte(input logic [31:0] word, input logic [1:0] idx);
        logic [7:0] b;
        case (idx)
            2'd0:    b = word[31:24];
            2'd1:    b = word[23:16];
            2'd2:    b = word[15:8];
            default: b = word[7:0];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/logip_cmd_ctrl_if.sv
// Command-in / transmitter-out handshake bundle of the command controller.
// Signal directions in the names are as seen from the controller.
interface logip_cmd_ctrl_if #(
    parameter int DATA_BITS       = 8,
    parameter int CMD_WIDTH_WORDS = 5
);
    logic [DATA_BITS*CMD_WIDTH_WORDS-1:0] cmd_i;
    logic                                 cmd_rdy_i;
    logic [DATA_BITS-1:0]                 tx_data_o;
    logic                                 tx_stb_o;
    logic                                 tx_busy_i;

    // Host side: UART receiver plus transmitter
    modport master (output cmd_i, cmd_rdy_i, tx_busy_i, input tx_data_o, tx_stb_o);
    // Controller side
    modport slave  (input cmd_i, cmd_rdy_i, tx_busy_i, output tx_data_o, tx_stb_o);
endinterface

// File: rtl/logip_cmd_ctrl_tx_seq.sv
// ID reply sequencer: walks the four ID bytes through the transmitter
// strobe/busy handshake (IDLE -> SEND -> HOLD -> WAIT -> SEND ...).
module logip_tx_seq
    import logip_pkg::*;
#(
    parameter int          DATA_BITS = 8,
    parameter logic [31:0] ID_WORD   = 32'h31414C53
) (
    input  logic                 clk_i,
    input  logic                 rst_in,
    input  logic                 i_start,
    input  logic                 i_tx_busy,
    output logic [DATA_BITS-1:0] o_tx_data,
    output logic                 o_tx_stb,
    output logic                 o_idle
);

    localparam logic [1:0] S_IDLE = ST_IDLE;
    localparam logic [1:0] S_SEND = ST_SEND;
    localparam logic [1:0] S_HOLD = ST_HOLD;
    localparam logic [1:0] S_WAIT = ST_WAIT;

    logic [1:0] r_state;
    logic [1:0] r_idx;

    assign o_idle = (r_state == S_IDLE);

    // Handshake FSM; tx data is only loaded on a strobe so it holds the last byte
    // NOTE: sequential state uses <= so every register updates together at the edge.
    always_ff @(posedge clk_i or negedge rst_in) begin
        if (!rst_in) begin
            r_state   <= S_IDLE;
            r_idx     <= 2'd0;
            o_tx_data <= '0;
            o_tx_stb  <= 1'b0;
        end else begin
            o_tx_stb <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_idx   <= 2'd0;
                        r_state <= S_SEND;
                    end
                end
                S_SEND: begin
                    if (!i_tx_busy) begin
                        o_tx_data <= DATA_BITS'(id_byte(ID_WORD, r_idx));
                        o_tx_stb  <= 1'b1;
                        r_state   <= S_HOLD;
                    end
                end
                // Busy is ignored here: the transmitter needs this cycle to raise it
                S_HOLD: r_state <= S_WAIT;
                default: begin
                    if (!i_tx_busy) begin
                        if (r_idx == 2'd3) begin
                            r_state <= S_IDLE;
                        end else begin
                            r_idx   <= r_idx + 2'd1;
                            r_state <= S_SEND;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: rtl/logip_cmd_ctrl.sv
// LogIP command controller: opcode decoder, sampler/trigger configuration
// registers, one-deep pending slot for commands arriving during an ID reply.
module logip_cmd_ctrl
    import logip_pkg::*;
#(
    parameter int          DATA_BITS       = 8,
    parameter int          CMD_WIDTH_WORDS = 5,
    parameter int          STAGES          = 4,
    parameter logic [31:0] ID_WORD         = 32'h31414C53
) (
    input  logic                  clk_i,
    input  logic                  rst_in,
    logip_cmd_ctrl_if.slave       bus,
    output logic [23:0]           divider_o,
    output logic [15:0]           read_cnt_o,
    output logic [15:0]           delay_cnt_o,
    output logic [7:0]            flags_o,
    output logic [STAGES*32-1:0]  trg_mask_o,
    output logic [STAGES*32-1:0]  trg_val_o,
    output logic [STAGES*32-1:0]  trg_cfg_o,
    output logic                  arm_o,
    output logic                  soft_rst_o,
    output logic                  xoff_o,
    output logic                  cmd_err_o,
    output logic                  cmd_drop_o
);

    localparam int CMD_W = DATA_BITS * CMD_WIDTH_WORDS;

    logic                         r_pend_vld;
    logic [CMD_W-1:0]             r_pend_cmd;
    logic [STAGES-1:0][31:0]      r_trg_mask;
    logic [STAGES-1:0][31:0]      r_trg_val;
    logic [STAGES-1:0][31:0]      r_trg_cfg;
    logic                         w_idle;
    logic                         w_exec_vld;
    logic [CMD_W-1:0]             w_exec_cmd;
    logic [7:0]                   w_op;
    logic                         w_start;
    logic                         w_is_trg;

    // Pick the command to execute: a waiting pending command beats a new arrival
    // NOTE: every always_comb output is assigned on every path so no latch is inferred.
    always_comb begin
        w_exec_vld = w_idle && (r_pend_vld || bus.cmd_rdy_i);
        w_exec_cmd = r_pend_vld ? r_pend_cmd : bus.cmd_i;
    end

    assign w_op     = w_exec_cmd[7:0];
    assign w_start  = w_exec_vld && (w_op == OP_ID);
    assign w_is_trg = (w_op[7:4] == OP_TRG_BASE[7:4]) && (w_op[1:0] != 2'd3);

    assign trg_mask_o = r_trg_mask;
    assign trg_val_o  = r_trg_val;
    assign trg_cfg_o  = r_trg_cfg;

    // Pending slot: refill on the execute cycle, park while busy, drop if full
    always_ff @(posedge clk_i or negedge rst_in) begin
        if (!rst_in) begin
            r_pend_vld <= 1'b0;
            r_pend_cmd <= '0;
            cmd_drop_o <= 1'b0;
        end else begin
            cmd_drop_o <= 1'b0;
            if (w_idle && r_pend_vld) begin
                r_pend_vld <= bus.cmd_rdy_i;
                if (bus.cmd_rdy_i) r_pend_cmd <= bus.cmd_i;
            end else if (!w_idle && bus.cmd_rdy_i) begin
                if (r_pend_vld) begin
                    cmd_drop_o <= 1'b1;
                end else begin
                    r_pend_vld <= 1'b1;
                    r_pend_cmd <= bus.cmd_i;
                end
            end
        end
    end

    // Opcode decode: configuration register writes and one-cycle strobes
    always_ff @(posedge clk_i or negedge rst_in) begin
        if (!rst_in) begin
            divider_o   <= '0;
            read_cnt_o  <= '0;
            delay_cnt_o <= '0;
            flags_o     <= '0;
            r_trg_mask  <= '0;
            r_trg_val   <= '0;
            r_trg_cfg   <= '0;
            xoff_o      <= 1'b0;
            arm_o       <= 1'b0;
            soft_rst_o  <= 1'b0;
            cmd_err_o   <= 1'b0;
        end else begin
            arm_o      <= 1'b0;
            soft_rst_o <= 1'b0;
            cmd_err_o  <= 1'b0;
            if (w_exec_vld) begin
                case (w_op)
                    OP_RESET: begin
                        soft_rst_o  <= 1'b1;
                        divider_o   <= '0;
                        read_cnt_o  <= '0;
                        delay_cnt_o <= '0;
                        flags_o     <= '0;
                        r_trg_mask  <= '0;
                        r_trg_val   <= '0;
                        r_trg_cfg   <= '0;
                        xoff_o      <= 1'b0;
                    end
                    OP_ARM:   arm_o  <= 1'b1;
                    OP_ID:    ;  // handled by the sequencer through w_start
                    OP_XON:   xoff_o <= 1'b0;
                    OP_XOFF:  xoff_o <= 1'b1;
                    OP_DIV:   divider_o <= w_exec_cmd[31:8];
                    OP_CNT: begin
                        read_cnt_o  <= w_exec_cmd[23:8];
                        delay_cnt_o <= w_exec_cmd[39:24];
                    end
                    OP_FLAGS: flags_o <= w_exec_cmd[15:8];
                    default: begin
                        if (w_is_trg) begin
                            case (w_op[1:0])
                                TRG_MASK: r_trg_mask[w_op[3:2]] <= w_exec_cmd[39:8];
                                TRG_VAL:  r_trg_val[w_op[3:2]]  <= w_exec_cmd[39:8];
                                default:  r_trg_cfg[w_op[3:2]]  <= w_exec_cmd[39:8];
                            endcase
                        end else begin
                            cmd_err_o <= 1'b1;
                        end
                    end
                endcase
            end
        end
    end

    logip_tx_seq #(
        .DATA_BITS (DATA_BITS),
        .ID_WORD   (ID_WORD)
    ) u_tx_seq (
        .clk_i     (clk_i),
        .rst_in    (rst_in),
        .i_start   (w_start),
        .i_tx_busy (bus.tx_busy_i),
        .o_tx_data (bus.tx_data_o),
        .o_tx_stb  (bus.tx_stb_o),
        .o_idle    (w_idle)
    );

endmodule

// File: tb/tb_logip_cmd_ctrl.sv
// Self-checking bench for logip_cmd_ctrl: randomized configuration traffic
// against a behavioural register model, plus ID reply, pending slot, soft
// reset, error opcodes and asynchronous reset scenarios.
module tb_logip_cmd_ctrl;

    localparam logic [31:0] ID_WORD = 32'h31414C53;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logip_cmd_ctrl_if #(.DATA_BITS(8), .CMD_WIDTH_WORDS(5)) bus();

    logic [23:0]  divider;
    logic [15:0]  read_cnt, delay_cnt;
    logic [7:0]   flags;
    logic [127:0] trg_mask, trg_val, trg_cfg;
    logic         arm, soft_rst, xoff, cmd_err, cmd_drop;

    logip_cmd_ctrl #(
        .DATA_BITS(8), .CMD_WIDTH_WORDS(5), .STAGES(4), .ID_WORD(ID_WORD)
    ) dut (
        .clk_i       (clk),
        .rst_in      (rst_n),
        .bus         (bus),
        .divider_o   (divider),
        .read_cnt_o  (read_cnt),
        .delay_cnt_o (delay_cnt),
        .flags_o     (flags),
        .trg_mask_o  (trg_mask),
        .trg_val_o   (trg_val),
        .trg_cfg_o   (trg_cfg),
        .arm_o       (arm),
        .soft_rst_o  (soft_rst),
        .xoff_o      (xoff),
        .cmd_err_o   (cmd_err),
        .cmd_drop_o  (cmd_drop)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Behavioural model of the configuration state
    logic [23:0] m_div;
    logic [15:0] m_rd, m_dl;
    logic [7:0]  m_flags;
    logic [31:0] m_mask [4];
    logic [31:0] m_val  [4];
    logic [31:0] m_cfg  [4];
    logic        m_xoff;
    logic [3:0]  e_pulse;   // {arm, soft_rst, cmd_err, cmd_drop}

    // Transmitter model and observers
    logic [7:0] rx_q [$];
    int busy_cnt = 0;
    int arm_cnt  = 0;
    int arm_at   = 0;

    // Transmitter: accepts a strobe, stays busy for 10 cycles
    always @(negedge clk) begin
        if (bus.tx_stb_o === 1'b1) begin
            rx_q.push_back(bus.tx_data_o);
            busy_cnt = 10;
        end
        if (busy_cnt > 0) begin
            bus.tx_busy_i = 1'b1;
            busy_cnt--;
        end else begin
            bus.tx_busy_i = 1'b0;
        end
        if (arm === 1'b1) begin
            arm_cnt++;
            arm_at = rx_q.size();
        end
    end

    function automatic void model_reset();
        m_div = '0; m_rd = '0; m_dl = '0; m_flags = '0; m_xoff = 1'b0;
        for (int s = 0; s < 4; s++) begin
            m_mask[s] = '0; m_val[s] = '0; m_cfg[s] = '0;
        end
    endfunction

    // Applies one command executed from IDLE, following the opcode table
    function automatic void model_exec(input logic [39:0] c);
        int op = int'(c[7:0]);
        e_pulse = 4'b0000;
        if (op == 8'h00) begin
            model_reset();
            e_pulse[2] = 1'b1;
        end else if (op == 8'h01) e_pulse[3] = 1'b1;
        else if (op == 8'h02) begin end
        else if (op == 8'h11) m_xoff = 1'b0;
        else if (op == 8'h13) m_xoff = 1'b1;
        else if (op == 8'h80) m_div = c[31:8];
        else if (op == 8'h81) begin m_rd = c[23:8]; m_dl = c[39:24]; end
        else if (op == 8'h82) m_flags = c[15:8];
        else if (op >= 8'hC0 && op <= 8'hCF && ((op - 8'hC0) % 4) != 3) begin
            int s = (op - 8'hC0) / 4;
            int r = (op - 8'hC0) % 4;
            if (r == 0) m_mask[s] = c[39:8];
            else if (r == 1) m_val[s] = c[39:8];
            else m_cfg[s] = c[39:8];
        end else e_pulse[1] = 1'b1;
    endfunction

    function automatic logic [448:0] dut_cfg();
        return {divider, read_cnt, delay_cnt, flags, trg_mask, trg_val, trg_cfg, xoff};
    endfunction

    function automatic logic [448:0] mdl_cfg();
        logic [127:0] mk, vl, cf;
        for (int s = 0; s < 4; s++) begin
            mk[32*s +: 32] = m_mask[s];
            vl[32*s +: 32] = m_val[s];
            cf[32*s +: 32] = m_cfg[s];
        end
        return {m_div, m_rd, m_dl, m_flags, mk, vl, cf, m_xoff};
    endfunction

    function automatic logic [7:0] exp_byte(input int i);
        return 8'((ID_WORD >> (24 - 8 * (i % 4))) & 32'hFF);
    endfunction

    // One cmd_rdy pulse; returns on the negedge after the sampling edge
    task automatic send_cmd(input logic [39:0] c);
        @(negedge clk);
        bus.cmd_i     = c;
        bus.cmd_rdy_i = 1'b1;
        @(negedge clk);
        bus.cmd_rdy_i = 1'b0;
    endtask

    // Bounded wait for n received bytes (and optionally the transmitter idle)
    task automatic wait_rx(input int n, input bit quiet, input int budget, input string name);
        bit ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk); #1;
            if (rx_q.size() >= n && (!quiet || bus.tx_busy_i == 1'b0)) begin
                ok = 1'b1;
                break;
            end
        end
        n_checks++;
        if (!ok) $display("FAIL %s_timeout: got %0d bytes, required %0d", name, rx_q.size(), n);
        else n_pass++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.cmd_i = '0;
        bus.cmd_rdy_i = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        n_checks++;
        if (dut_cfg() !== '0) $display("FAIL reset_cfg: got %h, required 0", dut_cfg());
        else n_pass++;
        n_checks++;
        if ({arm, soft_rst, cmd_err, cmd_drop, bus.tx_stb_o, bus.tx_data_o} !== 13'd0)
            $display("FAIL reset_pulses: got %b, required 0",
                     {arm, soft_rst, cmd_err, cmd_drop, bus.tx_stb_o, bus.tx_data_o});
        else n_pass++;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_divider();
        send_cmd(40'h00_00_12_34_80);
        model_exec(40'h00_00_12_34_80);
        n_checks++;
        if (divider !== 24'h001234) $display("FAIL div_value: got %h, required 001234", divider);
        else n_pass++;
        n_checks++;
        if (dut_cfg() !== mdl_cfg()) $display("FAIL div_others: got %h, required %h", dut_cfg(), mdl_cfg());
        else n_pass++;
    endtask

    task automatic test_random_cfg();
        logic [7:0] ops [12] = '{8'h00, 8'h01, 8'h11, 8'h13, 8'h80, 8'h81,
                                 8'h82, 8'hC0, 8'hC5, 8'hCA, 8'hCF, 8'hC3};
        for (int it = 0; it < 30; it++) begin
            logic [39:0] c;
            logic [7:0] op;
            int sel = $urandom_range(0, 15);
            if (sel < 12) op = ops[sel];
            else if (sel < 14) op = 8'($urandom_range(8'hC0, 8'hCF));
            else op = 8'($urandom);
            if (op == 8'h02) op = 8'h55;
            c = {32'($urandom), op};
            send_cmd(c);
            model_exec(c);
            n_checks++;
            if (dut_cfg() !== mdl_cfg())
                $display("FAIL rand_cfg op=%h: got %h, required %h", op, dut_cfg(), mdl_cfg());
            else n_pass++;
            n_checks++;
            if ({arm, soft_rst, cmd_err, cmd_drop} !== e_pulse)
                $display("FAIL rand_pulse op=%h: got %b, required %b", op,
                         {arm, soft_rst, cmd_err, cmd_drop}, e_pulse);
            else n_pass++;
            @(negedge clk);
            n_checks++;
            if ({arm, soft_rst, cmd_err, cmd_drop} !== 4'b0000)
                $display("FAIL rand_pulse_width op=%h: got %b, required 0000", op,
                         {arm, soft_rst, cmd_err, cmd_drop});
            else n_pass++;
        end
    endtask

    task automatic test_id_reply();
        rx_q.delete();
        send_cmd(40'h02);
        wait_rx(4, 1'b1, 200, "id");
        repeat (30) @(negedge clk);
        n_checks++;
        if (rx_q.size() != 4) $display("FAIL id_count: got %0d, required 4", rx_q.size());
        else n_pass++;
        for (int i = 0; i < 4 && i < rx_q.size(); i++) begin
            n_checks++;
            if (rx_q[i] !== exp_byte(i)) $display("FAIL id_byte%0d: got %h, required %h", i, rx_q[i], exp_byte(i));
            else n_pass++;
        end
        n_checks++;
        if (bus.tx_data_o !== exp_byte(3)) $display("FAIL id_hold: got %h, required %h", bus.tx_data_o, exp_byte(3));
        else n_pass++;
        n_checks++;
        if (dut_cfg() !== mdl_cfg()) $display("FAIL id_cfg: got %h, required %h", dut_cfg(), mdl_cfg());
        else n_pass++;
    endtask

    task automatic test_pending();
        rx_q.delete();
        arm_cnt = 0;
        send_cmd(40'h02);
        send_cmd(40'h01);
        n_checks++;
        if (arm !== 1'b0) $display("FAIL pend_early_arm: got %b, required 0", arm);
        else n_pass++;
        send_cmd({32'hDEADBEEF, 8'hC4});
        n_checks++;
        if (cmd_drop !== 1'b1) $display("FAIL pend_drop: got %b, required 1", cmd_drop);
        else n_pass++;
        wait_rx(4, 1'b1, 200, "pend");
        repeat (5) @(negedge clk);
        n_checks++;
        if (arm_cnt != 1 || arm_at != 4)
            $display("FAIL pend_arm: got %0d pulses after %0d bytes, required 1 after 4", arm_cnt, arm_at);
        else n_pass++;
        n_checks++;
        if (trg_mask[63:32] !== 32'h0 || dut_cfg() !== mdl_cfg())
            $display("FAIL pend_mask: got %h, required %h", dut_cfg(), mdl_cfg());
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        rx_q.delete();
        send_cmd(40'h02);
        send_cmd(40'h02);
        wait_rx(8, 1'b1, 400, "b2b");
        repeat (30) @(negedge clk);
        n_checks++;
        if (rx_q.size() != 8) $display("FAIL b2b_count: got %0d, required 8", rx_q.size());
        else n_pass++;
        for (int i = 0; i < 8 && i < rx_q.size(); i++) begin
            n_checks++;
            if (rx_q[i] !== exp_byte(i)) $display("FAIL b2b_byte%0d: got %h, required %h", i, rx_q[i], exp_byte(i));
            else n_pass++;
        end
    endtask

    task automatic test_soft_reset();
        logic [39:0] seq [3];
        seq[0] = 40'h13;
        seq[1] = {32'hA5A5A5A5, 8'hC9};
        seq[2] = {32'($urandom), 8'h81};
        foreach (seq[i]) begin
            send_cmd(seq[i]);
            model_exec(seq[i]);
        end
        n_checks++;
        if (trg_val[95:64] !== 32'hA5A5A5A5) $display("FAIL srst_pre: got %h, required a5a5a5a5", trg_val[95:64]);
        else n_pass++;
        send_cmd(40'h00);
        model_exec(40'h00);
        n_checks++;
        if (soft_rst !== 1'b1) $display("FAIL srst_pulse: got %b, required 1", soft_rst);
        else n_pass++;
        n_checks++;
        if (dut_cfg() !== '0) $display("FAIL srst_cfg: got %h, required 0", dut_cfg());
        else n_pass++;
    endtask

    task automatic test_err();
        logic [7:0] ops [4] = '{8'h13, 8'h11, 8'hC3, 8'h55};
        int err_seen = 0;
        foreach (ops[i]) begin
            logic [39:0] c = {32'($urandom), ops[i]};
            send_cmd(c);
            model_exec(c);
            if (cmd_err === 1'b1) err_seen++;
            n_checks++;
            if (dut_cfg() !== mdl_cfg() || {arm, soft_rst, cmd_err, cmd_drop} !== e_pulse)
                $display("FAIL err_op%h: got %h/%b, required %h/%b", ops[i], dut_cfg(),
                         {arm, soft_rst, cmd_err, cmd_drop}, mdl_cfg(), e_pulse);
            else n_pass++;
        end
        n_checks++;
        if (err_seen != 2) $display("FAIL err_count: got %0d, required 2", err_seen);
        else n_pass++;
    endtask

    task automatic test_async_reset();
        rx_q.delete();
        send_cmd({32'h0000_5678, 8'h80});
        model_exec({32'h0000_5678, 8'h80});
        send_cmd(40'h02);
        wait_rx(2, 1'b0, 200, "arst_wait");
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        n_checks++;
        if ({bus.tx_stb_o, bus.tx_data_o} !== 9'd0 || dut_cfg() !== '0)
            $display("FAIL arst_out: got stb/data %b/%h cfg %h, required 0", bus.tx_stb_o, bus.tx_data_o, dut_cfg());
        else n_pass++;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        n_checks++;
        if (rx_q.size() != 2) $display("FAIL arst_no_more: got %0d bytes, required 2", rx_q.size());
        else n_pass++;
        rx_q.delete();
        send_cmd(40'h02);
        wait_rx(4, 1'b1, 200, "arst_again");
        for (int i = 0; i < 4 && i < rx_q.size(); i++) begin
            n_checks++;
            if (rx_q[i] !== exp_byte(i)) $display("FAIL arst_byte%0d: got %h, required %h", i, rx_q[i], exp_byte(i));
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_divider();
        test_random_cfg();
        test_id_reply();
        repeat (3) @(negedge clk);
        test_pending();
        repeat (3) @(negedge clk);
        test_back_to_back();
        repeat (3) @(negedge clk);
        test_soft_reset();
        test_err();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
